// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl -- instruction-fetch sequencer for the IF stage.
//
// Drives the fetch PC and request to instruction memory, sequencing through
// IDLE -> FETCH -> (HOLD) and into FLUSH on any redirect.
//
// Parameters:
//   RESET_PC        PC value loaded on reset
// Ports:
//   clk             sole clock, rising edge
//   rst_n           asynchronous active-low reset
//   stall_in        downstream (ID/MEM) busy
//   redirect_valid  branch/jump taken this cycle
//   redirect_target new fetch address (low two bits forced to zero)
//   imem_ready      instruction memory returns data this cycle
//   imem_req        fetch request to instruction memory
//   pc              current fetch address
//   pc_stall        high whenever pc is not written this cycle
//   fetch_valid     instruction at pc valid for IF/ID capture
//   if_flush        flush IF/ID register
//   misalign_err    sticky: an accepted redirect had target[1:0] != 0
//   fetch_state     FSM state (IDLE=0, FETCH=1, HOLD=2, FLUSH=3)
//   stall_cycles    (FETCH_CTRL_PERF_EN) saturating count of stalled cycles
//   redirect_count  (FETCH_CTRL_PERF_EN) saturating count of redirects
//
// Optional feature macro: FETCH_CTRL_PERF_EN adds the two counter outputs.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] pc,
    output logic        pc_stall,
    output logic        fetch_valid,
    output logic        if_flush,
    output logic        misalign_err,
    output logic [1:0]  fetch_state
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] redirect_count
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] pc_nxt;
    logic        pc_wr;
    logic        redirect_acc;

    // A redirect is only accepted outside reset, so nothing moves while
    // rst_n is low even if redirect_valid is asserted.
    assign redirect_acc = rst_n & redirect_valid;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pc_wr       = 1'b0;
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        if_flush    = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    fetch_valid = 1'b1;
                    if (stall_in) begin
                        state_nxt = S_HOLD;
                    end else begin
                        pc_wr  = 1'b1;
                        pc_nxt = pc + 32'd4;
                    end
                end
            end
            S_HOLD: begin
                fetch_valid = 1'b1;
                if (!stall_in) begin
                    pc_wr     = 1'b1;
                    pc_nxt    = pc + 32'd4;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                if_flush  = 1'b1;
                state_nxt = S_FETCH;
            end
        endcase
        // Redirect overrides everything: returning data is dropped.
        if (redirect_acc) begin
            fetch_valid = 1'b0;
            pc_wr       = 1'b1;
            pc_nxt      = {redirect_target[31:2], 2'b00};
            state_nxt   = S_FLUSH;
        end
        if (!rst_n) begin
            imem_req    = 1'b0;
            fetch_valid = 1'b0;
            if_flush    = 1'b0;
            pc_wr       = 1'b0;
        end
    end

    assign pc_stall    = ~pc_wr;
    assign fetch_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (pc_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (redirect_valid && (redirect_count != '1)) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl -- self-checking bench for fetch_ctrl: directed scenarios
// followed by randomized traffic, compared cycle by cycle to a reference
// model expressed as the fetch rules (mode + pc + counters).
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] pc;
    logic        pc_stall;
    logic        fetch_valid;
    logic        if_flush;
    logic        misalign_err;
    logic [1:0]  fetch_state;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] redirect_count;
`endif

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_in        (stall_in),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_ready      (imem_ready),
        .imem_req        (imem_req),
        .pc              (pc),
        .pc_stall        (pc_stall),
        .fetch_valid     (fetch_valid),
        .if_flush        (if_flush),
        .misalign_err    (misalign_err),
        .fetch_state     (fetch_state)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .redirect_count  (redirect_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: mode 0 idle, 1 fetching, 2 holding data, 3 flushing.
    int unsigned m_mode;
    logic [31:0] m_pc;
    logic        m_mis;
    longint      m_sc;
    longint      m_rc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = RST_PC;
        m_mis  = 1'b0;
        m_sc   = 0;
        m_rc   = 0;
    endtask

    function automatic logic redir_now();
        return rst_n && redirect_valid;
    endfunction

    function automatic logic advance_now();
        if (redir_now() || !rst_n) return 1'b0;
        return (m_mode == 1 && imem_ready && !stall_in) || (m_mode == 2 && !stall_in);
    endfunction

    task automatic compare_all();
        logic r;
        r = redir_now();
        check("pc",          pc,           m_pc);
        check("state",       {30'b0, fetch_state}, m_mode);
        check("imem_req",    imem_req,     rst_n && m_mode == 1);
        check("fetch_valid", fetch_valid,  rst_n && !r && ((m_mode == 1 && imem_ready) || m_mode == 2));
        check("if_flush",    if_flush,     rst_n && m_mode == 3);
        check("pc_stall",    pc_stall,     !(r || advance_now()));
        check("misalign",    misalign_err, m_mis);
`ifdef FETCH_CTRL_PERF_EN
        check("stall_cycles",   stall_cycles,   m_sc[31:0]);
        check("redirect_count", redirect_count, m_rc[31:0]);
`endif
    endtask

    task automatic model_step();
        logic r;
        logic adv;
        r   = redir_now();
        adv = advance_now();
        if (!(r || adv)) m_sc = (m_sc < 64'hFFFF_FFFF) ? m_sc + 1 : m_sc;
        if (r) begin
            m_rc   = (m_rc < 64'hFFFF_FFFF) ? m_rc + 1 : m_rc;
            m_pc   = redirect_target & 32'hFFFF_FFFC;
            m_mis  = m_mis | (redirect_target % 4 != 0);
            m_mode = 3;
        end else begin
            if (adv) m_pc = m_pc + 32'd4;
            case (m_mode)
                0, 3:    m_mode = 1;
                1:       m_mode = (imem_ready && stall_in) ? 2 : 1;
                default: m_mode = stall_in ? 2 : 1;
            endcase
        end
    endtask

    // Called at posedge+1: apply inputs, check mid-cycle, advance model.
    task automatic cycle(input logic s, input logic rdy, input logic rv, input logic [31:0] tgt);
        stall_in        = s;
        imem_ready      = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    // Asserts reset mid-cycle (called at posedge+1), holds it, releases at posedge+1.
    task automatic do_reset();
        #2;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        stall_in       = 1'b0;
        #1;
        model_reset();
        check("rst_pc",       pc,          RST_PC);
        check("rst_imem_req", imem_req,    1'b0);
        check("rst_pc_stall", pc_stall,    1'b1);
        check("rst_state",    {30'b0, fetch_state}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        stall_in        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        imem_ready      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Zero-wait streaming: IDLE once, then 0x0, 0x4, 0x8, 0xC.
        cycle(0, 1, 0, 0);
        check("idle_first", {30'b0, fetch_state}, 32'd1);
        for (int unsigned i = 0; i < 4; i++) cycle(0, 1, 0, 0);
        check("pc_after_stream", pc, 32'h10);

        // Memory wait of three cycles at 0x10.
        for (int unsigned i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        check("pc_after_wait", pc, 32'h14);
        for (int unsigned i = 0; i < 3; i++) cycle(0, 1, 0, 0);

        // Downstream stall for two cycles when data returns at 0x20.
        check("pc_before_hold", pc, 32'h20);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("pc_after_hold", pc, 32'h24);

        // Redirect coinciding with returning data at 0x8.
        cycle(0, 1, 1, 32'h8);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 32'h100);
        check("flush_state", {30'b0, fetch_state}, 32'd3);
        cycle(0, 1, 0, 0);
        check("pc_redirect", pc, 32'h100);
        cycle(0, 1, 1, 32'h102);
        check("pc_misalign", pc, 32'h100);
        check("misalign_set", misalign_err, 1'b1);
        cycle(0, 1, 0, 0);

        // Wrap at the top of the address space.
        cycle(0, 1, 1, 32'hFFFF_FFFC);
        cycle(0, 1, 0, 0);
        check("pc_top", pc, 32'hFFFF_FFFC);
        cycle(0, 1, 0, 0);
        check("pc_wrap", pc, 32'h0);

        // Reset in the middle of a memory wait at 0x40.
        cycle(0, 1, 1, 32'h40);
        cycle(0, 1, 0, 0);
        imem_ready = 1'b0;
        do_reset();
        check("mis_cleared", misalign_err, 1'b0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("post_rst_pc", pc, 32'h4);

        // Randomized traffic.
        for (int unsigned i = 0; i < 600; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            if (i == 300) do_reset();
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port stall_in  input  1  downstream stall (ID or MEM stage busy).
REQ-005 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-006 SHALL have port redirect_target  input  32  new fetch address.
REQ-007 SHALL have port imem_ready  input  1  instruction memory returns data this cycle.
REQ-008 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-009 SHALL have port pc  output  32  current fetch address, driven to instruction memory.
REQ-010 SHALL have port pc_stall  output  1  high whenever pc does not advance this cycle.
REQ-011 SHALL have port fetch_valid  output  1  instruction at pc valid for IF/ID capture.
REQ-012 SHALL have port if_flush  output  1  flush IF/ID register.
REQ-013 SHALL have port misalign_err  output  1  sticky: redirect_target[1:0] was nonzero.
REQ-014 SHALL have port fetch_state  output  2  FSM state encoding (IDLE=0, FETCH=1, HOLD=2, FLUSH=3).

Function
REQ-015 SHALL implement a four-state FSM: IDLE, FETCH, HOLD, FLUSH.
REQ-016 IDLE: imem_req=0; unconditionally to FETCH next cycle unless redirect_valid (then FLUSH).
REQ-017 FETCH: imem_req=1; no imem_ready -> stay, pc held.
REQ-018 FETCH, imem_ready=1, stall_in=0: fetch_valid=1 same cycle, pc<=pc+4, stay FETCH (one instruction per cycle with zero-wait memory).
REQ-019 FETCH, imem_ready=1, stall_in=1: fetch_valid=1, pc held, go HOLD.
REQ-020 HOLD: imem_req=0, fetch_valid=1 held; when stall_in=0, pc<=pc+4 and go FETCH.
REQ-021 Any state, redirect_valid=1: pc<={redirect_target[31:2],2'b00}, go FLUSH; redirect beats stall_in and imem_ready; data returning that cycle is discarded (fetch_valid=0).
REQ-022 FLUSH: imem_req=0, if_flush=1, fetch_valid=0; next state FETCH, or FLUSH again with new target if redirect_valid repeats.
REQ-023 pc increment SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000), no error.
REQ-024 misalign_err SHALL set on any accepted redirect with target[1:0]!=0 and clear only on reset.
REQ-025 pc_stall SHALL equal the inverse of "pc is written this cycle".
REQ-026 fetch_valid, if_flush SHALL be combinational from state and inputs; pc, state, misalign_err registered.

Reset
REQ-027 On rst_n=0, asynchronously: state=IDLE, pc=RESET_PC, misalign_err=0, counters=0.
REQ-028 During reset: imem_req=0, fetch_valid=0, if_flush=0, pc_stall=1.
REQ-029 Reset asserted mid-fetch SHALL abandon the fetch; first post-reset request to RESET_PC occurs in the second cycle after rst_n rises.

Configuration
REQ-030 Macro FETCH_CTRL_PERF_EN SHALL, when defined, add outputs stall_cycles[31:0] (counts cycles with pc_stall=1 outside reset) and redirect_count[31:0] (counts accepted redirects), both saturating at 32'hFFFFFFFF.
REQ-031 Without FETCH_CTRL_PERF_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset release, imem_ready tied 1, stall_in=0 -> IDLE 1 cycle, then pc 0x0,0x4,0x8,0xC on consecutive cycles, fetch_valid=1 each.
REQ-033 imem_ready low 3 cycles at pc=0x10 -> imem_req=1, pc_stall=1 for 3 cycles, fetch_valid only on 4th cycle, then pc=0x14.
REQ-034 stall_in=1 for 2 cycles when data returns at pc=0x20 -> HOLD, fetch_valid=1 held, pc=0x20 held, then pc=0x24.
REQ-035 redirect_valid with target 0x100 coinciding with imem_ready at pc=0x8 -> fetch_valid=0, FLUSH 1 cycle with if_flush=1, next fetch pc=0x100; redirect to 0x102 -> pc=0x100, misalign_err=1.
REQ-036 Redirect to 0xFFFFFFFC, two fetches -> pc 0xFFFFFFFC then 0x00000000; assert rst_n=0 mid-wait -> pc=RESET_PC, imem_req=0 immediately.
REQ-037 With FETCH_CTRL_PERF_EN: scenario REQ-034 plus one redirect -> stall_cycles and redirect_count match cycle-counted reference model; counters read 0 after reset.
